rsa_uart_sequencer: RTL

Frame controller between the UART receive path and the modular-exponentiation engine. It collects three N-bit words from the byte deserializer (message, exponent, modulus), launches the engine, waits for completion, then streams the N-bit result back to the UART transmitter MSB-byte first. It is the only block that drives the engine's start and operand inputs.

---
 rtl/rsa_uart_pkg.sv | 16 +
 rtl/rsa_uart_sequencer_serializer.sv | 41 ++++
 rtl/rsa_uart_sequencer.sv | 105 ++++++++++
 3 files changed

// File: rtl/rsa_uart_pkg.sv
// Shared types and constants for the RSA UART frame sequencer.
package rsa_uart_pkg;

  localparam int N_DEFAULT = 16;
  localparam int BYTE_W    = 8;

  typedef enum logic [2:0] {
    S_MSG   = 3'd0,
    S_EXP   = 3'd1,
    S_MOD   = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_SEND  = 3'd5
  } seq_state_t;

endpackage

// File: rtl/rsa_uart_sequencer_serializer.sv
// Result shift register: loads the engine result, then emits it MSB byte first
// on each send strobe; last_o flags that the pending send is the final byte.
module result_serializer
  import rsa_uart_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int NBYTES = N / BYTE_W,
  parameter int BCNT_W = $clog2(NBYTES) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [N-1:0]      result_i,
  input  logic              send_i,
  output logic [BYTE_W-1:0] tx_byte_o,
  output logic              last_o
);

  logic [N-1:0]      shift_q;
  logic [BCNT_W-1:0] cnt_q;
  logic [BYTE_W-1:0] byte_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
    end else if (load_i) begin
      shift_q <= result_i;
      cnt_q   <= '0;
    end else if (send_i) begin
      byte_q  <= shift_q[N-1 -: BYTE_W];
      shift_q <= shift_q << BYTE_W;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign tx_byte_o = byte_q;
  assign last_o    = (cnt_q == BCNT_W'(NBYTES - 1));

endmodule

// File: rtl/rsa_uart_sequencer.sv
// Frame controller: collects message/exponent/modulus words, launches the
// modexp engine, and streams the result to the UART transmitter.
//
//   state   | meaning
//   S_MSG   | waiting for message word (reset state)
//   S_EXP   | waiting for exponent word
//   S_MOD   | waiting for modulus word
//   S_START | engine start pulse asserted
//   S_WAIT  | waiting for engine completion
//   S_SEND  | streaming result bytes, paced by tx_busy
module rsa_uart_sequencer
  import rsa_uart_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int NBYTES = N / BYTE_W,
  parameter int BCNT_W = $clog2(NBYTES) + 1
) (
  input  logic              iCE_CLK,
  input  logic              rst,
  input  logic              word_valid,
  input  logic [N-1:0]      word_in,
  output logic              eng_start,
  output logic [N-1:0]      eng_msg,
  output logic [N-1:0]      eng_exp,
  output logic [N-1:0]      eng_mod,
  input  logic              eng_done,
  input  logic [N-1:0]      eng_result,
  output logic [BYTE_W-1:0] tx_byte,
  output logic              tx_valid,
  input  logic              tx_busy,
  output logic              busy,
  output logic              err_overrun
);

  seq_state_t   state_q;
  logic         eng_start_q;
  logic [N-1:0] msg_q, exp_q, mod_q;
  logic         tx_valid_q;
  logic         err_q;
  logic         send_w;
  logic         load_w;
  logic         last_w;

  assign busy   = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_SEND);
  // tx_valid itself blocks a send, which enforces the 2-cycle minimum spacing
  assign send_w = (state_q == S_SEND) && !tx_busy && !tx_valid_q;
  assign load_w = (state_q == S_WAIT) && eng_done;

  always_ff @(posedge iCE_CLK or posedge rst) begin
    if (rst) begin
      state_q     <= S_MSG;
      eng_start_q <= 1'b0;
      msg_q       <= '0;
      exp_q       <= '0;
      mod_q       <= '0;
      tx_valid_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      tx_valid_q  <= send_w;
      case (state_q)
        S_MSG: if (word_valid) begin
          msg_q   <= word_in;
          state_q <= S_EXP;
        end
        S_EXP: if (word_valid) begin
          exp_q   <= word_in;
          state_q <= S_MOD;
        end
        S_MOD: if (word_valid) begin
          mod_q       <= word_in;
          eng_start_q <= 1'b1;
          state_q     <= S_START;
        end
        S_START: state_q <= S_WAIT;
        S_WAIT:  if (eng_done) state_q <= S_SEND;
        S_SEND:  if (send_w && last_w) state_q <= S_MSG;
        default: state_q <= S_MSG;
      endcase
      if (word_valid && busy) err_q <= 1'b1;
    end
  end

  result_serializer #(
    .N      (N),
    .NBYTES (NBYTES),
    .BCNT_W (BCNT_W)
  ) u_ser (
    .clk_i     (iCE_CLK),
    .rst_i     (rst),
    .load_i    (load_w),
    .result_i  (eng_result),
    .send_i    (send_w),
    .tx_byte_o (tx_byte),
    .last_o    (last_w)
  );

  assign eng_start   = eng_start_q;
  assign eng_msg     = msg_q;
  assign eng_exp     = exp_q;
  assign eng_mod     = mod_q;
  assign tx_valid    = tx_valid_q;
  assign err_overrun = err_q;

endmodule
